// File: rtl/set_mode_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module : set_mode_controller_pkg
// Brief  : Shared state encoding, field positions and display codes.
// Rev    : 1.0
// ============================================================================
package set_mode_controller_pkg;

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        T_DAY  = 3'd1,
        T_HOUR = 3'd2,
        T_MIN  = 3'd3,
        A_EN   = 3'd4,
        A_DAY  = 3'd5,
        A_HOUR = 3'd6,
        A_MIN  = 3'd7
    } state_e;

    localparam int EN_BIT  = 15;
    localparam int DAY_HI  = 14;
    localparam int DAY_LO  = 12;
    localparam int HOUR_HI = 11;
    localparam int HOUR_LO = 7;
    localparam int MT_HI   = 6;
    localparam int MT_LO   = 4;
    localparam int MU_HI   = 3;
    localparam int MU_LO   = 0;

    // CW codes double as the field selector of the incrementer
    localparam logic [1:0] CW_EN   = 2'b00;
    localparam logic [1:0] CW_MIN  = 2'b01;
    localparam logic [1:0] CW_HOUR = 2'b10;
    localparam logic [1:0] CW_DAY  = 2'b11;

    localparam logic [1:0] CW1_NONE  = 2'b00;
    localparam logic [1:0] CW1_TIME  = 2'b01;
    localparam logic [1:0] CW1_ALARM = 2'b10;

    localparam logic [1:0] S_CT   = 2'b00;
    localparam logic [1:0] S_EDIT = 2'b11;

    localparam logic [2:0] DAY_MAX  = 3'd6;
    localparam logic [4:0] HOUR_MAX = 5'd23;
    localparam logic [2:0] MT_MAX   = 3'd5;
    localparam logic [3:0] MU_MAX   = 4'd9;

endpackage
`default_nettype wire

// File: rtl/set_mode_controller_if.sv
`default_nettype none
// ============================================================================
// Module : set_mode_controller_if
// Brief  : Button/time inputs and display/commit outputs of the sequencer.
// Rev    : 1.0
// ============================================================================
interface set_mode_controller_if;
    logic        Mode;
    logic        Sel;
    logic        Inc;
    logic        Tick;
    logic [14:0] CT;
    logic [1:0]  S;
    logic [1:0]  CW;
    logic [1:0]  CW1;
    logic [15:0] ST;
    logic [15:0] Alarm;
    logic        TLoad;
    logic [14:0] TVal;

    modport master (
        output Mode, Sel, Inc, Tick, CT,
        input  S, CW, CW1, ST, Alarm, TLoad, TVal
    );

    modport slave (
        input  Mode, Sel, Inc, Tick, CT,
        output S, CW, CW1, ST, Alarm, TLoad, TVal
    );
endinterface
`default_nettype wire

// File: rtl/set_mode_controller_field_incrementer.sv
`default_nettype none
// ============================================================================
// Module : field_incrementer
// Brief  : Increments one field of a {day,hour,mt,mu} word with wrap.
// Rev    : 1.0
// ============================================================================
module field_incrementer
    import set_mode_controller_pkg::*;
(
    input  logic [14:0] word_i,
    input  logic [1:0]  field_i,
    output logic [14:0] word_o
);

    logic [2:0] w_day;
    logic [4:0] w_hour;
    logic [2:0] w_mt;
    logic [3:0] w_mu;

    assign w_day  = word_i[DAY_HI:DAY_LO];
    assign w_hour = word_i[HOUR_HI:HOUR_LO];
    assign w_mt   = word_i[MT_HI:MT_LO];
    assign w_mu   = word_i[MU_HI:MU_LO];

    // ">=" comparisons also pull any out-of-range captured value back to 0
    always_comb begin
        word_o = word_i;
        case (field_i)
            CW_DAY:  word_o[DAY_HI:DAY_LO]   = (w_day >= DAY_MAX) ? 3'd0 : w_day + 3'd1;
            CW_HOUR: word_o[HOUR_HI:HOUR_LO] = (w_hour >= HOUR_MAX) ? 5'd0 : w_hour + 5'd1;
            CW_MIN: begin
                if (w_mu >= MU_MAX) begin
                    word_o[MU_HI:MU_LO] = 4'd0;
                    word_o[MT_HI:MT_LO] = (w_mt >= MT_MAX) ? 3'd0 : w_mt + 3'd1;
                end else begin
                    word_o[MU_HI:MU_LO] = w_mu + 4'd1;
                end
            end
            default: word_o = word_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/set_mode_controller.sv
`default_nettype none
// ============================================================================
// Module : set_mode_controller
// Brief  : Front-panel sequencer for time/alarm editing with idle timeout.
// Rev    : 1.0
// ============================================================================
module set_mode_controller
    import set_mode_controller_pkg::*;
#(
    parameter int TIMEOUT = 30
) (
    input  logic                 Clk,
    input  logic                 Clr,
    set_mode_controller_if.slave bus
);

    state_e      state_q, state_d;
    logic [14:0] shadow_q, shadow_d;
    logic [15:0] alarm_q, alarm_d;
    logic [5:0]  idle_q, idle_d;
    logic        tload_q, tload_d;
    logic [14:0] tval_q, tval_d;

    logic        w_in_time;
    logic        w_in_alarm;
    logic [1:0]  w_cw;
    state_e      w_sel_next;
    logic [14:0] w_inc_in;
    logic [14:0] w_inc_out;
    logic [5:0]  w_idle_inc;

    assign w_in_time  = (state_q == T_DAY) || (state_q == T_HOUR) || (state_q == T_MIN);
    assign w_in_alarm = (state_q == A_EN) || (state_q == A_DAY) ||
                        (state_q == A_HOUR) || (state_q == A_MIN);
    assign w_idle_inc = idle_q + 6'd1;
    assign w_inc_in   = w_in_time ? shadow_q : alarm_q[14:0];

    always_comb begin
        w_cw       = CW_EN;
        w_sel_next = RUN;
        case (state_q)
            T_DAY:  begin w_cw = CW_DAY;  w_sel_next = T_HOUR; end
            T_HOUR: begin w_cw = CW_HOUR; w_sel_next = T_MIN;  end
            T_MIN:  begin w_cw = CW_MIN;  w_sel_next = T_DAY;  end
            A_EN:   begin w_cw = CW_EN;   w_sel_next = A_DAY;  end
            A_DAY:  begin w_cw = CW_DAY;  w_sel_next = A_HOUR; end
            A_HOUR: begin w_cw = CW_HOUR; w_sel_next = A_MIN;  end
            A_MIN:  begin w_cw = CW_MIN;  w_sel_next = A_EN;   end
            default: begin w_cw = CW_EN;  w_sel_next = RUN;    end
        endcase
    end

    field_incrementer u_field_inc (
        .word_i  (w_inc_in),
        .field_i (w_cw),
        .word_o  (w_inc_out)
    );

    always_ff @(posedge Clk) begin
        if (Clr) begin
            state_q  <= RUN;
            shadow_q <= 15'h0000;
            alarm_q  <= 16'h0000;
            idle_q   <= 6'd0;
            tload_q  <= 1'b0;
            tval_q   <= 15'h0000;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            alarm_q  <= alarm_d;
            idle_q   <= idle_d;
            tload_q  <= tload_d;
            tval_q   <= tval_d;
        end
    end

    // Button priority Mode > Sel > Inc; any press outranks Tick
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        alarm_d  = alarm_q;
        idle_d   = idle_q;
        tload_d  = 1'b0;
        tval_d   = tval_q;
        if (state_q == RUN) begin
            idle_d = 6'd0;
            if (bus.Mode) begin
                shadow_d = bus.CT;
                state_d  = T_DAY;
            end
        end else if (bus.Mode) begin
            idle_d = 6'd0;
            if (w_in_time) begin
                tval_d  = shadow_q;
                tload_d = 1'b1;
                state_d = A_EN;
            end else begin
                state_d = RUN;
            end
        end else if (bus.Sel) begin
            idle_d  = 6'd0;
            state_d = w_sel_next;
        end else if (bus.Inc) begin
            idle_d = 6'd0;
            if (w_in_time) begin
                shadow_d = w_inc_out;
            end else if (w_cw == CW_EN) begin
                alarm_d[EN_BIT] = ~alarm_q[EN_BIT];
            end else begin
                alarm_d = {alarm_q[EN_BIT], w_inc_out};
            end
        end else if (bus.Tick) begin
            if (w_idle_inc == 6'(TIMEOUT)) begin
                idle_d  = 6'd0;
                state_d = RUN;
            end else begin
                idle_d = w_idle_inc;
            end
        end
    end

    assign bus.S     = (w_in_time || w_in_alarm) ? S_EDIT : S_CT;
    assign bus.CW    = w_cw;
    assign bus.CW1   = w_in_time ? CW1_TIME : (w_in_alarm ? CW1_ALARM : CW1_NONE);
    assign bus.ST    = w_in_time ? {1'b0, shadow_q} : (w_in_alarm ? alarm_q : 16'h0000);
    assign bus.Alarm = alarm_q;
    assign bus.TLoad = tload_q;
    assign bus.TVal  = tval_q;

endmodule
`default_nettype wire

// File: tb/tb_set_mode_controller.sv
`default_nettype none
// ============================================================================
// Module : tb_set_mode_controller
// Brief  : Randomized scoreboard bench for the front-panel sequencer.
// Rev    : 1.0
// ============================================================================
module tb_set_mode_controller;

    localparam int TO = 3;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    set_mode_controller_if bus();

    set_mode_controller #(.TIMEOUT(TO)) dut (
        .Clk (clk),
        .Clr (clr),
        .bus (bus)
    );

    typedef struct packed {
        logic [1:0]  s;
        logic [1:0]  cw;
        logic [1:0]  cw1;
        logic [15:0] st;
        logic [15:0] alarm;
        logic        tload;
    } obs_t;

    obs_t        exp_q[$];
    logic [14:0] commit_q[$];
    int          checks = 0;
    int          errors = 0;

    // Reference model: group 0 run / 1 time / 2 alarm, cursor index, fields as integers
    int grp = 0, cur = 0, idle = 0;
    int sh_day = 0, sh_hour = 0, sh_min = 0;
    int al_en = 0, al_day = 0, al_hour = 0, al_min = 0;
    int ct_d = 0, ct_h = 0, ct_m = 0;

    function automatic logic [14:0] pack_t(input int d, input int h, input int m);
        logic [14:0] w;
        w[14:12] = 3'(d);
        w[11:7]  = 5'(h);
        w[6:4]   = 3'(m / 10);
        w[3:0]   = 4'(m % 10);
        return w;
    endfunction

    // Time cursor order: day, hour, min; alarm: enable, day, hour, min
    function automatic int cw_of(input int g, input int c);
        if (g == 1) return 3 - c;
        if (g == 2) return (c == 0) ? 0 : 4 - c;
        return 0;
    endfunction

    task automatic cyc(input logic c, input logic m, input logic s, input logic i, input logic t);
        obs_t e;
        int   f;
        logic tl;
        @(negedge clk);
        clr      = c;
        bus.Mode = m;
        bus.Sel  = s;
        bus.Inc  = i;
        bus.Tick = t;
        bus.CT   = pack_t(ct_d, ct_h, ct_m);
        tl = 1'b0;
        f  = cw_of(grp, cur);
        if (c) begin
            grp = 0; cur = 0; idle = 0;
            sh_day = 0; sh_hour = 0; sh_min = 0;
            al_en = 0; al_day = 0; al_hour = 0; al_min = 0;
        end else if (grp == 0) begin
            if (m) begin
                sh_day = ct_d; sh_hour = ct_h; sh_min = ct_m;
                grp = 1; cur = 0; idle = 0;
            end
        end else if (m) begin
            if (grp == 1) begin
                commit_q.push_back(pack_t(sh_day, sh_hour, sh_min));
                tl  = 1'b1;
                grp = 2;
            end else begin
                grp = 0;
            end
            cur = 0; idle = 0;
        end else if (s) begin
            cur  = (cur + 1) % ((grp == 1) ? 3 : 4);
            idle = 0;
        end else if (i) begin
            idle = 0;
            if (grp == 1) begin
                if (f == 3) sh_day  = (sh_day + 1) % 7;
                if (f == 2) sh_hour = (sh_hour + 1) % 24;
                if (f == 1) sh_min  = (sh_min + 1) % 60;
            end else begin
                if (f == 0) al_en   = 1 - al_en;
                if (f == 3) al_day  = (al_day + 1) % 7;
                if (f == 2) al_hour = (al_hour + 1) % 24;
                if (f == 1) al_min  = (al_min + 1) % 60;
            end
        end else if (t) begin
            idle = idle + 1;
            if (idle == TO) begin
                grp = 0; cur = 0; idle = 0;
            end
        end
        e.s     = (grp == 0) ? 2'b00 : 2'b11;
        e.cw    = 2'(cw_of(grp, cur));
        e.cw1   = 2'(grp);
        e.alarm = {1'(al_en), pack_t(al_day, al_hour, al_min)};
        e.st    = (grp == 0) ? 16'h0000 :
                  (grp == 1) ? {1'b0, pack_t(sh_day, sh_hour, sh_min)} : e.alarm;
        e.tload = tl;
        exp_q.push_back(e);
    endtask

    obs_t        mon_e;
    obs_t        mon_a;
    logic [14:0] mon_tv;

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e  = exp_q.pop_front();
            mon_a  = {bus.S, bus.CW, bus.CW1, bus.ST, bus.Alarm, bus.TLoad};
            checks = checks + 1;
            if (mon_a !== mon_e) begin
                errors = errors + 1;
                $display("FAIL outputs t=%0t: got S=%b CW=%b CW1=%b ST=%h Alarm=%h TLoad=%b, want S=%b CW=%b CW1=%b ST=%h Alarm=%h TLoad=%b",
                         $time, mon_a.s, mon_a.cw, mon_a.cw1, mon_a.st, mon_a.alarm, mon_a.tload,
                         mon_e.s, mon_e.cw, mon_e.cw1, mon_e.st, mon_e.alarm, mon_e.tload);
            end
            if (bus.TLoad === 1'b1) begin
                checks = checks + 1;
                if (commit_q.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL commit t=%0t: got TLoad with TVal=%h, want no commit", $time, bus.TVal);
                end else begin
                    mon_tv = commit_q.pop_front();
                    if (bus.TVal !== mon_tv) begin
                        errors = errors + 1;
                        $display("FAIL tval t=%0t: got %h, want %h", $time, bus.TVal, mon_tv);
                    end
                end
            end
        end
    end

    initial begin
        bus.Mode = 1'b0; bus.Sel = 1'b0; bus.Inc = 1'b0; bus.Tick = 1'b0;
        bus.CT   = 15'h0000;

        // Reset held two cycles with Mode pulsing
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);

        // Day 3, 23:59: hour wrap then commit
        ct_d = 3; ct_h = 23; ct_m = 59;
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);

        // Alarm: enable toggle, then minutes through 09->10 and 59->00
        cyc(0, 0, 0, 1, 0);
        for (int k = 0; k < 3; k++) cyc(0, 0, 1, 0, 0);
        for (int k = 0; k < 60; k++) cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0);

        // Day 6 wrap, commit, back to run
        ct_d = 6; ct_h = 12; ct_m = 34;
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);

        // Timeout in T_HOUR, then Sel restarting the count
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0);
        for (int k = 0; k < 3; k++) begin cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 0); end
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 1);
        for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0, 1);

        // Priority: Mode+Inc in T_MIN, Sel+Inc in A_EN; reset mid-edit
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 1, 0, 1, 0);
        cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);

        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 19) == 0) begin
                ct_d = int'($urandom_range(0, 6));
                ct_h = int'($urandom_range(0, 23));
                ct_m = int'($urandom_range(0, 59));
            end
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 3) == 0);
        end

        @(posedge clk);
        #3;
        checks = checks + 1;
        if (commit_q.size() != 0 || exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: got %0d commits and %0d observations pending, want 0 and 0",
                     commit_q.size(), exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
